// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier dispatch block.
package mult_pkg;

  localparam int unsigned DefaultW = 32;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWaitClr  = 3'd2,
    StWaitDone = 3'd3,
    StHold     = 3'd4
  } mult_state_e;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers, explicit occupancy count.
module mult_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mult_dispatch.sv
// Queues operand pairs and feeds them one at a time to an external sequential multiplier.
module mult_dispatch
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = DefaultW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_product,
  input  logic           mul_done,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic           busy
);

  mult_state_e state_q;

  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [2*W-1:0]         fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;

  assign op_ready  = !fifo_full;
  assign fifo_push = op_valid && op_ready;
  // Pop exactly when the FSM loads the head into mul_a/mul_b.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == StIdle) || ((state_q == StHold) && res_ready));
  assign busy      = (state_q != StIdle) || (fifo_count != '0);

  mult_op_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({op_a, op_b}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      mul_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            {mul_a, mul_b} <= fifo_head;
            mul_start      <= 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: state_q <= StWaitClr;
        // Done may still be high from the previous job; wait for it to drop first.
        StWaitClr: begin
          if (!mul_done) state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (mul_done) begin
            res_data  <= mul_product;
            res_valid <= 1'b1;
            state_q   <= StHold;
          end
        end
        StHold: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!fifo_empty) begin
              {mul_a, mul_b} <= fifo_head;
              mul_start      <= 1'b1;
              state_q        <= StIssue;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_dispatch.sv
// Scoreboard bench for mult_dispatch with a behavioural sequential-multiplier model.
module tb_mult_dispatch;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned P     = 2 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid, op_ready;
  logic [W-1:0] op_a, op_b;
  logic         mul_start;
  logic [W-1:0] mul_a, mul_b;
  logic [P-1:0] mul_product;
  logic         mul_done;
  logic         res_valid, res_ready;
  logic [P-1:0] res_data;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;
  int n_results = 0;
  int lat_fix  = 0;

  logic [P-1:0] exp_q [$];
  logic [P-1:0] iss_q [$];

  always #5 clk = ~clk;

  mult_dispatch #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy)
  );

  function automatic logic [P-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [P-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [P-1:0] act,
                     input logic [P-1:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
  endtask

  // Sequential multiplier: clears done one cycle after sampling start, then
  // raises done with the product after a latency; done stays high until the next job.
  logic [W-1:0] m_a, m_b;
  logic         m_clr, m_run;
  int           m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done    <= 1'b0;
      mul_product <= '0;
      m_clr       <= 1'b0;
      m_run       <= 1'b0;
      m_cnt       <= 0;
      m_a         <= '0;
      m_b         <= '0;
    end else if (mul_start) begin
      m_a   <= mul_a;
      m_b   <= mul_b;
      m_clr <= 1'b1;
    end else if (m_clr) begin
      m_clr       <= 1'b0;
      mul_done    <= 1'b0;
      mul_product <= 64'hDEAD_BEEF_0BAD_F00D;
      m_run       <= 1'b1;
      m_cnt       <= (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 5));
    end else if (m_run) begin
      if (m_cnt <= 1) begin
        mul_done    <= 1'b1;
        mul_product <= ref_mul(m_a, m_b);
        m_run       <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Monitor: issue order, result order, hold stability.
  logic         hold_prev;
  logic [P-1:0] data_prev;
  always @(negedge clk) begin
    logic [P-1:0] e;
    if (rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (mul_start) begin
        n_starts++;
        if (iss_q.size() == 0) chk(1'b0, "unexpected_start", {mul_a, mul_b}, '0);
        else begin
          e = iss_q.pop_front();
          chk({mul_a, mul_b} == e, "issue_order", {mul_a, mul_b}, e);
        end
      end
      if (res_valid) chk(!mul_start, "no_start_in_hold", P'(mul_start), '0);
      if (hold_prev) begin
        chk(res_valid, "hold_valid", P'(res_valid), 1);
        chk(res_data == data_prev, "hold_data", res_data, data_prev);
      end
      if (res_valid && res_ready) begin
        n_results++;
        if (exp_q.size() == 0) chk(1'b0, "unexpected_result", res_data, '0);
        else begin
          e = exp_q.pop_front();
          chk(res_data == e, "result", res_data, e);
        end
      end
      hold_prev <= res_valid && !res_ready;
      data_prev <= res_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!op_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_ready) chk(1'b0, "push_timeout", P'(op_ready), 1);
    else begin
      exp_q.push_back(ref_mul(a, b));
      iss_q.push_back({a, b});
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [P-1:0] req, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(res_valid && res_ready) && n < 300);
    chk(res_valid && res_ready && res_data == req, name, res_data, req);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(exp_q.size() == 0 && !busy, "drain", P'(exp_q.size()), 0);
  endtask

  initial begin
    logic [P-1:0] held;
    int           s0, r0, n;
    bit           gen_done;

    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(op_ready, "rst_op_ready", P'(op_ready), 1);
    chk(!res_valid, "rst_res_valid", P'(res_valid), 0);
    chk(!busy, "rst_busy", P'(busy), 0);
    chk(!mul_start, "rst_mul_start", P'(mul_start), 0);
    chk(res_data == '0, "rst_res_data", res_data, '0);
    chk({mul_a, mul_b} == '0, "rst_mul_ab", {mul_a, mul_b}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single job, one start pulse, one-cycle result
    push_op(32'd3, 32'hFFFF_FFFC);
    wait_result(64'hFFFF_FFFF_FFFF_FFF4, "mul_3_m4");
    @(negedge clk);
    chk(!res_valid, "valid_one_cycle", P'(res_valid), 0);
    chk(n_starts == 1, "one_start", P'(n_starts), 1);
    @(posedge clk); #1;

    // Corner operands
    push_op(32'h8000_0000, 32'hFFFF_FFFF);
    push_op(32'd0, 32'd12345);
    wait_result(64'h0000_0000_8000_0000, "min_times_m1");
    wait_result(64'd0, "zero_times_x");
    @(posedge clk); #1;

    // Back-pressure: fill the FIFO behind a held result
    lat_fix   = 2;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(32'(i * 7 + 1), 32'(-(i + 2)));
    op_valid = 1'b1; op_a = 32'd1000; op_b = 32'd1001;
    chk(!op_ready, "op_ready_full", P'(op_ready), 0);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(res_valid, "first_result_held", P'(res_valid), 1);
    held = res_data;
    s0   = n_starts;
    repeat (10) begin @(posedge clk); #1; end
    chk(res_valid, "held_valid_10", P'(res_valid), 1);
    chk(res_data == held, "held_data_10", res_data, held);
    chk(n_starts == s0, "no_start_while_held", P'(n_starts), P'(s0));
    chk(!op_ready, "still_full", P'(op_ready), 0);
    res_ready = 1'b1;
    push_op(32'd1000, 32'd1001);
    drain();
    lat_fix = 0;

    // Random traffic with random downstream back-pressure
    gen_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_op($urandom, $urandom);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    drain();

    // Reset while a job waits for done and two more are queued
    lat_fix = 30;
    push_op(32'd11, 32'd13);
    push_op(32'd17, 32'd19);
    push_op(32'd23, 32'd29);
    repeat (6) begin @(posedge clk); #1; end
    chk(busy, "busy_before_rst", P'(busy), 1);
    rst = 1'b1;
    #1;
    chk(!res_valid, "rst_mid_valid", P'(res_valid), 0);
    chk(!busy, "rst_mid_busy", P'(busy), 0);
    chk(!mul_start, "rst_mid_start", P'(mul_start), 0);
    exp_q.delete();
    iss_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    lat_fix = 0;
    s0 = n_starts;
    r0 = n_results;
    repeat (40) begin @(posedge clk); #1; end
    chk(n_starts == s0, "no_start_after_rst", P'(n_starts), P'(s0));
    chk(n_results == r0, "no_result_after_rst", P'(n_results), P'(r0));
    chk(!busy, "idle_after_rst", P'(busy), 0);

    push_op(32'd7, 32'd6);
    wait_result(64'd42, "post_rst_job");
    @(posedge clk); #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_dispatch.md
MULT_DISPATCH -- requirements
Module: mult_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter W, default 32, operand width; product width 2*W.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port op_valid  in  1  upstream operand pair valid.
REQ-006 SHALL have port op_ready  out  1  FIFO not full.
REQ-007 SHALL have port op_a  in  W  multiplicand, two's complement.
REQ-008 SHALL have port op_b  in  W  multiplier, two's complement.
REQ-009 SHALL have port mul_start  out  1  one-cycle start pulse to the sequential multiplier.
REQ-010 SHALL have port mul_a  out  W  multiplicand to the multiplier.
REQ-011 SHALL have port mul_b  out  W  multiplier operand to the multiplier.
REQ-012 SHALL have port mul_product  in  2W  signed product from the multiplier.
REQ-013 SHALL have port mul_done  in  1  multiplier done level.
REQ-014 SHALL have port res_valid  out  1  result held for downstream.
REQ-015 SHALL have port res_ready  in  1  downstream accepts result.
REQ-016 SHALL have port res_data  out  2W  captured signed product.
REQ-017 SHALL have port busy  out  1  high when FSM is not IDLE or FIFO is non-empty.

Function
REQ-018 SHALL push {op_a,op_b} when op_valid and op_ready are both high; op_ready = (count != DEPTH).
REQ-019 SHALL, on push and pop in the same cycle, keep the count unchanged; at full, SHALL accept a push only after a pop has freed an entry.
REQ-020 SHALL use wrapping read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT_CLR, WAIT_DONE and HOLD.
REQ-022 SHALL transition IDLE->ISSUE when the FIFO is non-empty, popping the head into registered mul_a/mul_b.
REQ-023 SHALL drive mul_start=1 for exactly one cycle while in ISSUE, then SHALL transition ISSUE->WAIT_CLR.
REQ-024 SHALL stay in WAIT_CLR until mul_done==0 (the multiplier clears done one cycle after sampling start), then SHALL go to WAIT_DONE; stale done SHALL never be captured.
REQ-025 SHALL, in WAIT_DONE on mul_done==1, register mul_product into res_data, set res_valid=1, and go to HOLD.
REQ-026 SHALL, in HOLD with res_ready==1, clear res_valid, then SHALL go to ISSUE if the FIFO is non-empty (popping in the same cycle) or to IDLE otherwise.
REQ-027 SHALL hold res_data and res_valid stable in HOLD while res_ready==0; no new mul_start SHALL be issued.
REQ-028 SHALL hold mul_a/mul_b constant from ISSUE through WAIT_DONE.
REQ-029 SHALL issue operands in strict FIFO order, one multiplication in flight.
REQ-030 SHALL make throughput = multiplier latency + 3 cycles per job when res_ready is held high.

Reset
REQ-031 SHALL, on rst, set the FSM to IDLE, pointers and count to 0, and mul_start, res_valid and busy to 0; res_data, mul_a and mul_b SHALL reset to 0.
REQ-032 SHALL, on rst mid-operation, discard all queued jobs and the in-flight job; after deassertion no result SHALL appear until a new push.

Structure
REQ-033 SHALL place state encodings (IDLE=0 .. HOLD=4, 3 bits) and default W in shared package mult_pkg.
REQ-034 SHALL implement the operand FIFO as sub-module mult_op_fifo (DEPTH, 2W data, push/pop/full/empty/count).

Verification
REQ-035 SHALL cover: push (3,-4) with res_ready=1 -> one mul_start pulse, then res_data=0xFFFFFFFF_FFFFFFF4 with res_valid for 1 cycle.
REQ-036 SHALL cover: push 5 pairs back-to-back with DEPTH=4 -> op_ready low on the 5th until first pop; results returned in push order.
REQ-037 SHALL cover: (-2147483648,-1) -> res_data=0x00000000_80000000; (0,12345) -> 0.
REQ-038 SHALL cover: res_ready=0 for 10 cycles after result -> res_data stable, no mul_start, then release -> next job issued.
REQ-039 SHALL cover: rst asserted during WAIT_DONE with 2 jobs queued -> res_valid=0, busy=0, no further mul_start.
REQ-040 SHALL cover: mul_done held high from a prior job at ISSUE -> FSM waits in WAIT_CLR, captures only the new product.
